// File: rtl/lcc_resp_rx_if.sv
// +----------------------------------------------------------------------------+
// | lcc_resp_rx_if : serial line and response outputs of the LCC response UART  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface lcc_resp_rx_if #(
  parameter int BYTES = 4
);
  logic               RX;
  logic [7:0]         oData;
  logic               oValid;
  logic [8*BYTES-1:0] oFrame;
  logic               oFrameValid;
  logic               oFrameErr;
  logic               oBusy;

  modport slave (
    input  RX,
    output oData, oValid, oFrame, oFrameValid, oFrameErr, oBusy
  );

  modport master (
    output RX,
    input  oData, oValid, oFrame, oFrameValid, oFrameErr, oBusy
  );
endinterface

`default_nettype wire

// File: rtl/lcc_resp_rx.sv
// +----------------------------------------------------------------------------+
// | lcc_resp_rx : UART receiver grouping BYTES bytes into LCC response frames  |
// | Option macro LCC_RX_PARITY_EN selects 8E1 instead of 8N1.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lcc_resp_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int BYTES        = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  wire logic      clk,
  input  wire logic      reset,
  lcc_resp_rx_if.slave   bus
);
  localparam int c_cw  = $clog2(CLKS_PER_BIT);
  localparam int c_tw  = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam int c_nw  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [c_cw-1:0] c_half    = c_cw'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cw-1:0] c_full    = c_cw'(CLKS_PER_BIT - 1);
  localparam logic [c_tw-1:0] c_to_last = c_tw'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [c_nw-1:0] c_last    = c_nw'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef LCC_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t             r_state;
  logic [1:0]         r_sync;
  logic               r_rx_prev;
  logic [c_cw-1:0]    r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic [c_nw-1:0]    r_count;
  logic [c_tw-1:0]    r_to_cnt;
  logic [7:0]         r_slot [BYTES];
  logic [7:0]         r_data;
  logic               r_valid;
  logic [8*BYTES-1:0] r_frame;
  logic               r_frame_valid;
  logic               r_frame_err;
  logic               r_busy;
  logic               w_rx;
  logic               w_good;
  logic [8*BYTES-1:0] w_frame;

  assign w_rx = r_sync[1];

`ifdef LCC_RX_PARITY_EN
  logic r_par_err;
  assign w_good = w_rx & ~r_par_err;
`else
  assign w_good = w_rx;
`endif

  // Frame image with the byte now completing placed into its slot.
  always_comb begin
    w_frame = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_frame[i*8 +: 8] = (c_nw'(i) == r_count) ? r_shift : r_slot[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_sync        <= 2'b11;
      r_rx_prev     <= 1'b1;
      r_cnt         <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_count       <= '0;
      r_to_cnt      <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
      for (int i = 0; i < BYTES; i++) r_slot[i] <= '0;
`ifdef LCC_RX_PARITY_EN
      r_par_err     <= 1'b0;
`endif
    end else begin
      r_sync        <= {r_sync[0], bus.RX};
      r_rx_prev     <= w_rx;
      r_valid       <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // Expiry and a start edge on the same clk: the new byte opens a fresh frame.
          if (r_count != '0) begin
            if (r_to_cnt == c_to_last) begin
              r_count     <= '0;
              r_to_cnt    <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end else begin
            r_to_cnt <= '0;
          end
          if (r_rx_prev && !w_rx) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == c_half) begin
            r_cnt <= '0;
            r_bit <= '0;
            if (!w_rx) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == c_full) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
`ifdef LCC_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef LCC_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == c_full) begin
            r_cnt     <= '0;
            r_par_err <= ^{r_shift, w_rx};
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_cnt == c_full) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_to_cnt <= '0;
            r_state  <= w_rx ? S_IDLE : S_BREAK;
            if (w_good) begin
              r_data          <= r_shift;
              r_valid         <= 1'b1;
              r_slot[r_count] <= r_shift;
              if (r_count == c_last) begin
                r_frame       <= w_frame;
                r_frame_valid <= 1'b1;
                r_count       <= '0;
              end else begin
                r_count <= r_count + 1'b1;
              end
            end else begin
              r_frame_err <= (r_count != '0);
              r_count     <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (!w_rx) begin
            r_cnt <= '0;
          end else if (r_cnt == c_full) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oData       = r_data;
  assign bus.oValid      = r_valid;
  assign bus.oFrame      = r_frame;
  assign bus.oFrameValid = r_frame_valid;
  assign bus.oFrameErr   = r_frame_err;
  assign bus.oBusy       = r_busy;

endmodule

`default_nettype wire
